// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the EX-stage multiply sequencer.
package mul_sequencer_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 6;

  // Decode values that select the multiply in EX
  localparam logic [2:0] MUL_CTRL = 3'b011;
  localparam logic [5:0] MULT     = 6'b011000;

  // Sequencer state encodings
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: magnitude load, iterative add/shift, signed fix-up into HI/LO.
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              finish_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic              neg_q;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] add_val;
  logic [DATA_W:0]   sum;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] result;

  // Operand magnitudes, per-step sum and final signed product
  always_comb begin
    a_mag   = (signed_i && a_i[DATA_W-1]) ? (~a_i + DATA_W'(1)) : a_i;
    b_mag   = (signed_i && b_i[DATA_W-1]) ? (~b_i + DATA_W'(1)) : b_i;
    add_val = mplier_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q} + {1'b0, add_val};
    prod    = {acc_q, mplier_q};
    result  = neg_q ? (~prod + PROD_W'(1)) : prod;
  end

  // Accumulator and multiplier shift register; carry shifts into acc MSB
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= a_mag;
      mplier_q <= b_mag;
      acc_q    <= '0;
      neg_q    <= signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
    end else if (step_i) begin
      acc_q    <= sum[DATA_W:1];
      mplier_q <= {sum[0], mplier_q[DATA_W-1:1]};
    end
  end

  // HI/LO only change on the finish strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (finish_i) begin
      hi_o <= result[PROD_W-1:DATA_W];
      lo_o <= result[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller for EX: stalls the pipe while iterating, writes HI/LO.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, finish;

  // State and iteration counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, datapath strobes; flush wins over everything except reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        finish  = !flush_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status decode; stall drops in DONE so the mult leaves EX that cycle
  always_comb begin
    stall_o = ((state_q == IDLE) && start_i && !flush_i) || (state_q == RUN);
    busy_o  = (state_q != IDLE);
    done_o  = finish;
  end

  mul_shift_add_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .step_i   (step),
    .finish_i (finish),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

endmodule
